nibbler_sequencer: RTL and testbench
====================================

// Module: nibbler_sequencer
// PURPOSE
//  Fetch/phase sequencer feeding the Nibbler micro-ROM decoder: owns PC, instruction register (IR),
//  phase toggle and flag register. Produces instruction/flagsOut/phaseOut for the decoder; consumes
//  its incPC/notLoadPC/notLoadFlags strobes. Sits between program ROM, ALU and the decoder.
// PARAMETERS
//  PC_W     12  program-counter / program-ROM address width
//  INSTR_W   8  program-ROM data width (opcode nibble + operand nibble)
// PORTS
//  clk           in   1       system clock, rising edge
//  reset         in   1       asynchronous, active-high; clears all state
//  rom_data      in   INSTR_W program-ROM byte at pc_addr (combinational read)
//  incPC         in   1       decoder: advance PC
//  notLoadPC     in   1       decoder: active-low PC load (jump)
//  notLoadFlags  in   1       decoder: active-low flag capture
//  alu_carry     in   1       ALU carry-out, active-high
//  alu_zero      in   1       ALU result==0, active-high
//  pc_addr       out  PC_W    program-ROM address
//  instruction   out  4       IR[7:4], opcode to decoder
//  operand       out  4       IR[3:0], immediate nibble
//  mem_addr      out  PC_W    {IR[3:0], rom_data}; jump target / data-RAM address
//  phaseOut      out  1       0 = fetch, 1 = execute
//  flagsOut      out  2       {nCarry, nZero}, active-low (decoder JC jumps on flagsOut[1]==0)
// BEHAVIOUR
//  - One clock; reset asynchronous active-high. Reset values: pc_addr=0, IR=8'h00 (instruction=0,
//    operand=0), phaseOut=0, flagsOut=2'b11, FSM=FETCH.
//  - FSM FETCH(phaseOut=0) -> EXEC(phaseOut=1) -> FETCH; one state per clock, no stalls.
//  - FETCH edge: IR <= rom_data; PC <= PC+1 when incPC=1 (decoder drives 1 in phase 0).
//  - EXEC edge: notLoadPC=0 -> PC <= mem_addr (has priority over incPC);
//    else incPC=1 -> PC <= PC+1 (skips 2nd byte); else PC holds. IR holds.
//  - Flags: captured only on EXEC edge with notLoadFlags=0: flagsOut <= {~alu_carry, ~alu_zero};
//    otherwise held. notLoadFlags ignored in FETCH.
//  - Instruction latency: byte at PC visible on instruction 1 clk after FETCH edge;
//    full instruction = 2 clks.
//  - PC arithmetic modulo 2^PC_W: 12'hFFF + 1 -> 12'h000, no flag side effect.
//  - Simultaneous incPC=1 and notLoadPC=0 in EXEC: load wins.
//  - Reset mid-EXEC: immediate clear; first post-reset edge is a FETCH of address 0.
//  - mem_addr purely combinational; valid only while phaseOut=1.
// CONFIGURATION
//  - NIBBLER_STEP_EN defined: adds inputs run (1) and step (1, single-cycle pulse) and FSM state HOLD.
//    FETCH -> HOLD instead of EXEC when run=0.
//    HOLD -> EXEC on step=1 or run=1.
//    In HOLD: phaseOut=0, PC/IR/flags frozen, and incPC/notLoadPC/notLoadFlags ignored.
//  - Undefined: no run/step ports, no HOLD state; free-running FETCH/EXEC.
// STRUCTURE
//  - nibbler_pkg:
//    - PC_W/INSTR_W defaults
//    - phase_e {FETCH, EXEC, HOLD}
//    - opcode_e (JC..NORM, 4'h0..4'hF)
//    - FLAGS_RESET = 2'b11
//  - Sub-module nibbler_pc: PC register with load/inc/hold, async reset, wraps modulo 2^PC_W.
//  - IR, flag register and FSM stay in nibbler_sequencer.
// TESTING
//  1. Assert reset mid-EXEC with PC=12'h123.
//     -> pc_addr=0, flagsOut=2'b11, phaseOut=0 same cycle; first FETCH reads address 0.
//  2. ROM[0]=8'h4A (LIT 0xA), ROM[1]=8'hA3.
//     -> instruction=4'h4, operand=4'hA after edge 1; pc_addr 0->1->1 (EXEC incPC=0).
//  3. ROM[4]=8'hC2, ROM[5]=8'h5A (JMP), EXEC notLoadPC=0, incPC=1.
//     -> mem_addr=12'h25A, pc_addr=12'h25A after EXEC edge.
//  4. EXEC notLoadFlags=0, alu_carry=1, alu_zero=0.
//     -> flagsOut=2'b01.
//     Next EXEC notLoadFlags=1 with alu_carry=0 -> flagsOut remains 2'b01.
//  5. pc_addr=12'hFFF, FETCH incPC=1.
//     -> pc_addr=12'h000.
//     EXEC incPC=1 from 12'hFFE -> 12'hFFF.
//  6. NIBBLER_STEP_EN, run=0: FSM parks in HOLD with PC frozen for 10 clks.
//     One step pulse -> exactly one EXEC then FETCH -> HOLD.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler fetch/phase sequencer.
// Optional single-step support is enabled with NIBBLER_STEP_EN.
package nibbler_pkg;

    localparam int PC_W_DEF    = 12;
    localparam int INSTR_W_DEF = 8;

    // Flags are active-low {nCarry, nZero}; reset means "no carry, not zero".
    localparam logic [1:0] FLAGS_RESET = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HOLD  = 2'd2
    } phase_e;

    typedef enum logic [3:0] {
        OP_JC    = 4'h0,
        OP_JNC   = 4'h1,
        OP_JZ    = 4'h2,
        OP_JNZ   = 4'h3,
        OP_LIT   = 4'h4,
        OP_ADDI  = 4'h5,
        OP_CMPI  = 4'h6,
        OP_NANDI = 4'h7,
        OP_LD    = 4'h8,
        OP_ADDM  = 4'h9,
        OP_CMPM  = 4'hA,
        OP_NANDM = 4'hB,
        OP_JMP   = 4'hC,
        OP_ST    = 4'hD,
        OP_OUT   = 4'hE,
        OP_NORM  = 4'hF
    } opcode_e;

endpackage

// File: rtl/nibbler_pc.sv
// Program counter: load has priority over increment, otherwise holds.
// Increment wraps modulo 2^PC_W.
module nibbler_pc
    import nibbler_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    // PC register with async clear; jump target beats increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= '0;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + PC_W'(1);
    end

endmodule

// File: rtl/nibbler_sequencer.sv
// Nibbler fetch/execute sequencer: owns IR, flags and the phase FSM,
// drives the program-ROM address through nibbler_pc.
// Define NIBBLER_STEP_EN to add run/step ports and the HOLD state.
module nibbler_sequencer
    import nibbler_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               incPC,
    input  logic               notLoadPC,
    input  logic               notLoadFlags,
    input  logic               alu_carry,
    input  logic               alu_zero,
`ifdef NIBBLER_STEP_EN
    input  logic               run,
    input  logic               step,
`endif
    output logic [PC_W-1:0]    pc_addr,
    output logic [3:0]         instruction,
    output logic [3:0]         operand,
    output logic [PC_W-1:0]    mem_addr,
    output logic               phaseOut,
    output logic [1:0]         flagsOut
);

    phase_e             state;
    logic [INSTR_W-1:0] ir;
    logic               pc_load;
    logic               pc_inc;

    // HOLD is excluded from both terms, so decoder strobes are ignored there
    assign pc_load = (state == EXEC) && !notLoadPC;
    assign pc_inc  = ((state == FETCH) || (state == EXEC)) && incPC;

    nibbler_pc #(.PC_W(PC_W)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (mem_addr),
        .pc       (pc_addr)
    );

    // Jump/data address: operand nibble of IR glued to the second ROM byte
    assign mem_addr    = PC_W'({ir[3:0], rom_data});
    assign instruction = ir[INSTR_W-1 -: 4];
    assign operand     = ir[3:0];

    // Phase FSM with registered phase output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            phaseOut <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
`ifdef NIBBLER_STEP_EN
                    if (run) begin
                        state    <= EXEC;
                        phaseOut <= 1'b1;
                    end else begin
                        state    <= HOLD;
                        phaseOut <= 1'b0;
                    end
`else
                    state    <= EXEC;
                    phaseOut <= 1'b1;
`endif
                end
                EXEC: begin
                    state    <= FETCH;
                    phaseOut <= 1'b0;
                end
`ifdef NIBBLER_STEP_EN
                HOLD: begin
                    if (step || run) begin
                        state    <= EXEC;
                        phaseOut <= 1'b1;
                    end else begin
                        state    <= HOLD;
                        phaseOut <= 1'b0;
                    end
                end
`endif
                default: begin
                    state    <= FETCH;
                    phaseOut <= 1'b0;
                end
            endcase
        end
    end

    // Instruction register: loaded on the fetch edge only
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ir <= '0;
        else if (state == FETCH)
            ir <= rom_data;
    end

    // Flag register: active-low capture of ALU status on execute edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flagsOut <= FLAGS_RESET;
        else if ((state == EXEC) && !notLoadFlags)
            flagsOut <= {~alu_carry, ~alu_zero};
    end

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Directed bench for nibbler_sequencer with a behavioural program ROM.
module tb_nibbler_sequencer;

    logic        clk;
    logic        reset;
    logic [7:0]  rom_data;
    logic        incPC;
    logic        notLoadPC;
    logic        notLoadFlags;
    logic        alu_carry;
    logic        alu_zero;
`ifdef NIBBLER_STEP_EN
    logic        run;
    logic        step;
`endif
    logic [11:0] pc_addr;
    logic [3:0]  instruction;
    logic [3:0]  operand;
    logic [11:0] mem_addr;
    logic        phaseOut;
    logic [1:0]  flagsOut;

    logic [7:0]  rom [0:4095];
    int          errors = 0;
    int          checks = 0;

    assign rom_data = rom[pc_addr];

    nibbler_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .rom_data     (rom_data),
        .incPC        (incPC),
        .notLoadPC    (notLoadPC),
        .notLoadFlags (notLoadFlags),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
`ifdef NIBBLER_STEP_EN
        .run          (run),
        .step         (step),
`endif
        .pc_addr      (pc_addr),
        .instruction  (instruction),
        .operand      (operand),
        .mem_addr     (mem_addr),
        .phaseOut     (phaseOut),
        .flagsOut     (flagsOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = 8'h4A;
        rom[12'h001] = 8'hA3;
        rom[12'h004] = 8'hC2;
        rom[12'h005] = 8'h5A;
        rom[12'h25E] = 8'hCF;
        rom[12'h25F] = 8'hFD;

        reset        = 1'b1;
        incPC        = 1'b0;
        notLoadPC    = 1'b1;
        notLoadFlags = 1'b1;
        alu_carry    = 1'b0;
        alu_zero     = 1'b0;
`ifdef NIBBLER_STEP_EN
        run          = 1'b1;
        step         = 1'b0;
`endif
        tick();
        tick();
        chk("rst_pc",    pc_addr,     32'h0);
        chk("rst_flags", flagsOut,    32'h3);
        chk("rst_phase", phaseOut,    32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_oper",  operand,     32'h0);
        reset = 1'b0;

        // LIT 0xA fetch, execute without increment
        incPC = 1'b1;
        tick();
        chk("lit_instr", instruction, 32'h4);
        chk("lit_oper",  operand,     32'hA);
        chk("lit_pc",    pc_addr,     32'h1);
        chk("lit_phase", phaseOut,    32'h1);
        incPC = 1'b0;
        tick();
        chk("lit_pc_hold", pc_addr,     32'h1);
        chk("lit_phase0",  phaseOut,    32'h0);
        chk("lit_ir_hold", instruction, 32'h4);

        // walk to address 4: fetch, skip, fetch, hold
        incPC = 1'b1;
        tick();
        chk("walk_ir", instruction, 32'hA);
        chk("walk_pc2", pc_addr, 32'h2);
        tick();
        chk("walk_skip", pc_addr, 32'h3);
        tick();
        incPC = 1'b0;
        tick();
        chk("walk_pc4", pc_addr, 32'h4);

        // JMP 0x25A with incPC also asserted: load wins
        incPC = 1'b1;
        tick();
        chk("jmp_instr", instruction, 32'hC);
        chk("jmp_maddr", mem_addr,    32'h25A);
        notLoadPC = 1'b0;
        tick();
        chk("jmp_pc", pc_addr, 32'h25A);
        notLoadPC = 1'b1;

        // flags ignored on fetch edge, captured on execute edge
        notLoadFlags = 1'b0;
        alu_carry    = 1'b1;
        alu_zero     = 1'b1;
        tick();
        chk("flag_fetch_ign", flagsOut, 32'h3);
        alu_zero = 1'b0;
        tick();
        chk("flag_cap", flagsOut, 32'h1);
        chk("flag_pc",  pc_addr,  32'h25C);
        notLoadFlags = 1'b1;
        alu_carry    = 1'b0;
        alu_zero     = 1'b1;
        tick();
        tick();
        chk("flag_hold", flagsOut, 32'h1);
        chk("flag_pc2",  pc_addr,  32'h25E);

        // jump to 0xFFD and wrap through the top of the address space
        tick();
        chk("wrap_maddr", mem_addr, 32'hFFD);
        notLoadPC = 1'b0;
        tick();
        notLoadPC = 1'b1;
        chk("wrap_jmp", pc_addr, 32'hFFD);
        tick();
        chk("wrap_ffe", pc_addr, 32'hFFE);
        tick();
        chk("exec_inc_fff", pc_addr, 32'hFFF);
        tick();
        chk("wrap_000",   pc_addr,  32'h000);
        chk("wrap_flags", flagsOut, 32'h1);
        incPC = 1'b0;
        tick();
        chk("wrap_hold0", pc_addr, 32'h000);

        // reach 0x123 then reset in the middle of an execute phase
        rom[12'h000] = 8'hC1;
        rom[12'h001] = 8'h23;
        incPC = 1'b1;
        tick();
        chk("mid_maddr", mem_addr, 32'h123);
        notLoadPC = 1'b0;
        tick();
        notLoadPC = 1'b1;
        incPC     = 1'b0;
        tick();
        chk("mid_pc",    pc_addr,  32'h123);
        chk("mid_phase", phaseOut, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pc",    pc_addr,     32'h0);
        chk("mid_rst_flags", flagsOut,    32'h3);
        chk("mid_rst_phase", phaseOut,    32'h0);
        chk("mid_rst_instr", instruction, 32'h0);
        rom[12'h000] = 8'h4A;
        #2;
        reset = 1'b0;
        incPC = 1'b1;
        tick();
        chk("post_rst_instr", instruction, 32'h4);
        chk("post_rst_oper",  operand,     32'hA);
        chk("post_rst_pc",    pc_addr,     32'h1);
        chk("post_rst_phase", phaseOut,    32'h1);

`ifdef NIBBLER_STEP_EN
        // park in HOLD, then single-step one execute phase
        incPC = 1'b0;
        tick();
        chk("hold_pre_phase", phaseOut, 32'h0);
        run   = 1'b0;
        incPC = 1'b1;
        tick();
        chk("hold_enter_pc",    pc_addr,  32'h2);
        chk("hold_enter_phase", phaseOut, 32'h0);
        notLoadPC    = 1'b0;
        notLoadFlags = 1'b0;
        alu_carry    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_pc",    pc_addr,  32'h2);
            chk("hold_phase", phaseOut, 32'h0);
        end
        chk("hold_flags", flagsOut, 32'h3);
        notLoadPC    = 1'b1;
        notLoadFlags = 1'b1;
        incPC        = 1'b0;
        step         = 1'b1;
        tick();
        step = 1'b0;
        chk("step_exec", phaseOut, 32'h1);
        tick();
        chk("step_fetch", phaseOut, 32'h0);
        chk("step_pc",    pc_addr,  32'h2);
        tick();
        chk("step_rehold", phaseOut, 32'h0);
        tick();
        chk("step_parked", phaseOut, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
